// File: rtl/ibex_rvfi_pkg.sv
// +--------------------------------------------------------------------------+
// | ibex_rvfi_pkg : shared RVFI retirement record and FIFO state types       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package ibex_rvfi_pkg;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [63:0]     order;
        logic [31:0]     insn;
        logic [XLEN-1:0] pc_rdata;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
        logic            trap;
        logic            halt;
    } rvfi_rec_t;

    typedef enum logic [1:0] {
        RVFI_IDLE   = 2'd0,
        RVFI_RUN    = 2'd1,
        RVFI_HALTED = 2'd2,
        RVFI_ERROR  = 2'd3
    } rvfi_fifo_state_e;

endpackage

`default_nettype wire

// File: rtl/ibex_rvfi_order_chk.sv
// +--------------------------------------------------------------------------+
// | ibex_rvfi_order_chk : per-lane retirement order match and next order     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ibex_rvfi_order_chk #(
    parameter int NRET = 1
) (
    input  logic [63:0]            exp_i,
    input  logic [NRET-1:0]        valid_i,
    input  logic [NRET-1:0][63:0]  order_i,
    output logic                   match_o,
    output logic [1:0]             cnt_o,
    output logic [63:0]            exp_next_o
);

    logic [NRET-1:0] w_lane_ok;

    // Lane k must carry exp + k; idle lanes never cause a mismatch.
    for (genvar k = 0; k < NRET; k++) begin : g_lane
        assign w_lane_ok[k] = !valid_i[k] || (order_i[k] == (exp_i + 64'(k)));
    end

    always_comb begin
        cnt_o = '0;
        for (int k = 0; k < NRET; k++) begin
            cnt_o = cnt_o + {1'b0, valid_i[k]};
        end
    end

    assign match_o    = &w_lane_ok;
    assign exp_next_o = exp_i + {62'd0, cnt_o};

endmodule

`default_nettype wire

// File: rtl/ibex_rvfi_retire_fifo.sv
// +--------------------------------------------------------------------------+
// | ibex_rvfi_retire_fifo : multi-lane RVFI retirement buffer with checking  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ibex_rvfi_retire_fifo
    import ibex_rvfi_pkg::*;
#(
    parameter int          NRET        = 1,
    parameter int          DEPTH       = 8,
    parameter logic [63:0] ORDER_START = 64'd1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NRET-1:0]              ret_valid_i,
    input  rvfi_rec_t [NRET-1:0]         ret_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output rvfi_rec_t                    out_rec_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output rvfi_fifo_state_e             state_o,
    output logic                         overflow_o,
    output logic                         order_err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int FW = LW + 1;
    localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

    rvfi_rec_t        mem_q [DEPTH];
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [63:0]      exp_q, exp_d;
    rvfi_fifo_state_e state_q, state_d;
    logic             overflow_q, overflow_d;
    logic             order_err_q, order_err_d;

    logic [NRET-1:0][63:0] w_orders;
    logic                  w_match;
    logic [1:0]            w_cnt;
    logic [63:0]           w_exp_next;
    logic                  w_any_valid;
    logic                  w_proto_err;
    logic                  w_push_halt;
    logic                  w_pop;
    logic                  w_push;
    logic [FW-1:0]         w_free;

    for (genvar k = 0; k < NRET; k++) begin : g_ord
        assign w_orders[k] = ret_i[k].order;
    end

    ibex_rvfi_order_chk #(
        .NRET (NRET)
    ) u_order_chk (
        .exp_i      (exp_q),
        .valid_i    (ret_valid_i),
        .order_i    (w_orders),
        .match_o    (w_match),
        .cnt_o      (w_cnt),
        .exp_next_o (w_exp_next)
    );

    assign w_any_valid = |ret_valid_i;
    assign out_valid_o = (level_q != '0);
    assign w_pop       = out_valid_o & out_ready_i;
    assign w_free      = DEPTH_F - FW'(level_q) + FW'(w_pop);

    // Lanes must be compacted, and a halting record must be the last valid lane.
    always_comb begin
        w_proto_err = (state_q == RVFI_HALTED) && w_any_valid;
        w_push_halt = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            if (ret_valid_i[k] && ret_i[k].halt) begin
                w_push_halt = 1'b1;
            end
            if (k > 0) begin
                if (ret_valid_i[k] && !ret_valid_i[k-1]) begin
                    w_proto_err = 1'b1;
                end
                if (ret_valid_i[k] && ret_valid_i[k-1] && ret_i[k-1].halt) begin
                    w_proto_err = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_push      = 1'b0;
        state_d     = state_q;
        exp_d       = exp_q;
        overflow_d  = overflow_q;
        order_err_d = order_err_q;
        if (w_any_valid && (state_q != RVFI_ERROR)) begin
            if (w_proto_err || !w_match) begin
                order_err_d = 1'b1;
                state_d     = RVFI_ERROR;
            end else if (FW'(w_cnt) > w_free) begin
                overflow_d = 1'b1;
                state_d    = RVFI_ERROR;
            end else begin
                w_push  = 1'b1;
                exp_d   = w_exp_next;
                state_d = w_push_halt ? RVFI_HALTED : RVFI_RUN;
            end
        end
    end

    assign wptr_d  = wptr_q + (w_push ? PW'(w_cnt) : PW'(0));
    assign rptr_d  = rptr_q + PW'(w_pop);
    assign level_d = level_q + (w_push ? LW'(w_cnt) : LW'(0)) - LW'(w_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            level_q     <= '0;
            exp_q       <= ORDER_START;
            state_q     <= RVFI_IDLE;
            overflow_q  <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            level_q     <= level_d;
            exp_q       <= exp_d;
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            order_err_q <= order_err_d;
        end
    end

    // Storage carries no reset; the zero output when empty hides stale contents.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NRET; k++) begin
            if (rst_ni && w_push && ret_valid_i[k]) begin
                mem_q[wptr_q + PW'(k)] <= ret_i[k];
            end
        end
    end

    assign out_rec_o   = out_valid_o ? mem_q[rptr_q] : '0;
    assign level_o     = level_q;
    assign state_o     = state_q;
    assign overflow_o  = overflow_q;
    assign order_err_o = order_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ibex_rvfi_retire_fifo.sv
// +--------------------------------------------------------------------------+
// | tb_ibex_rvfi_retire_fifo : directed bench for single- and dual-lane FIFO |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ibex_rvfi_retire_fifo;
    import ibex_rvfi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic             a_rst_n;
    logic [0:0]       a_valid;
    rvfi_rec_t [0:0]  a_ret;
    logic             a_ready;
    logic             a_ovalid;
    rvfi_rec_t        a_out;
    logic [3:0]       a_level;
    rvfi_fifo_state_e a_state;
    logic             a_ovf;
    logic             a_oerr;

    logic             b_rst_n;
    logic [1:0]       b_valid;
    rvfi_rec_t [1:0]  b_ret;
    logic             b_ready;
    logic             b_ovalid;
    rvfi_rec_t        b_out;
    logic [3:0]       b_level;
    rvfi_fifo_state_e b_state;
    logic             b_ovf;
    logic             b_oerr;

    ibex_rvfi_retire_fifo #(.NRET(1), .DEPTH(8), .ORDER_START(64'd1)) u_dut_a (
        .clk_i       (clk),
        .rst_ni      (a_rst_n),
        .ret_valid_i (a_valid),
        .ret_i       (a_ret),
        .out_valid_o (a_ovalid),
        .out_ready_i (a_ready),
        .out_rec_o   (a_out),
        .level_o     (a_level),
        .state_o     (a_state),
        .overflow_o  (a_ovf),
        .order_err_o (a_oerr)
    );

    ibex_rvfi_retire_fifo #(.NRET(2), .DEPTH(8), .ORDER_START(64'd1)) u_dut_b (
        .clk_i       (clk),
        .rst_ni      (b_rst_n),
        .ret_valid_i (b_valid),
        .ret_i       (b_ret),
        .out_valid_o (b_ovalid),
        .out_ready_i (b_ready),
        .out_rec_o   (b_out),
        .level_o     (b_level),
        .state_o     (b_state),
        .overflow_o  (b_ovf),
        .order_err_o (b_oerr)
    );

    function automatic rvfi_rec_t mk(input logic [63:0] ord, input logic h);
        rvfi_rec_t r;
        r.order    = ord;
        r.insn     = 32'h0000_0013 ^ ord[31:0];
        r.pc_rdata = 32'h8000_0000 + {ord[29:0], 2'b00};
        r.rd_addr  = ord[4:0];
        r.rd_wdata = ~ord[31:0];
        r.trap     = ord[0];
        r.halt     = h;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rec(input string tag, input rvfi_rec_t obs, input rvfi_rec_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed order=0x%0h pc=0x%0h expected order=0x%0h pc=0x%0h",
                   tag, obs.order, obs.pc_rdata, exp.order, exp.pc_rdata);
        end
    endtask

    task automatic reset_a();
        a_valid = '0;
        a_rst_n = 1'b0;
        tick();
        a_rst_n = 1'b1;
    endtask

    task automatic reset_b();
        b_valid = '0;
        b_rst_n = 1'b0;
        tick();
        b_rst_n = 1'b1;
    endtask

    task automatic fill_a_1_to_8();
        for (int i = 1; i <= 8; i++) begin
            a_valid  = 1'b1;
            a_ret[0] = mk(64'(i), 1'b0);
            tick();
        end
        a_valid = 1'b0;
    endtask

    task automatic push_b(input logic [1:0] v, input rvfi_rec_t r0, input rvfi_rec_t r1);
        b_valid  = v;
        b_ret[0] = r0;
        b_ret[1] = r1;
        tick();
        b_valid  = 2'b00;
    endtask

    initial begin
        a_rst_n = 1'b0; a_valid = '0; a_ret[0] = '0; a_ready = 1'b0;
        b_rst_n = 1'b0; b_valid = '0; b_ret[0] = '0; b_ret[1] = '0; b_ready = 1'b0;
        tick();
        tick();

        check("a_rst_level",  a_level,  0);
        check("a_rst_ovalid", a_ovalid, 0);
        check("a_rst_state",  a_state,  RVFI_IDLE);
        check_rec("a_rst_rec", a_out, '0);
        check("a_rst_ovf",    a_ovf,    0);
        check("a_rst_oerr",   a_oerr,   0);
        check("b_rst_level",  b_level,  0);

        // Single-lane fill to full with the consumer stalled.
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        a_valid = 1'b1; a_ret[0] = mk(64'd1, 1'b0);
        tick();
        check("a_first_ovalid", a_ovalid, 1);
        check("a_first_state",  a_state,  RVFI_RUN);
        check("a_first_level",  a_level,  1);
        for (int i = 2; i <= 8; i++) begin
            a_ret[0] = mk(64'(i), 1'b0);
            tick();
        end
        a_valid = 1'b0;
        check("a_full_level", a_level, 8);
        check_rec("a_full_head", a_out, mk(64'd1, 1'b0));
        check("a_full_state", a_state, RVFI_RUN);
        check("a_full_ovf",   a_ovf,   0);
        check("a_full_oerr",  a_oerr,  0);
        tick();
        check_rec("a_stall_hold", a_out, mk(64'd1, 1'b0));

        // Full with simultaneous pop: push accepted.
        a_valid = 1'b1; a_ret[0] = mk(64'd9, 1'b0); a_ready = 1'b1;
        tick();
        a_valid = 1'b0; a_ready = 1'b0;
        check("a_pushpop_level", a_level, 8);
        check("a_pushpop_ovf",   a_ovf,   0);
        check("a_pushpop_head",  a_out.order, 2);
        check("a_pushpop_state", a_state, RVFI_RUN);

        // Full without pop: overflow, then drain still yields 1..8.
        reset_a();
        check("a_rst2_level", a_level, 0);
        check("a_rst2_state", a_state, RVFI_IDLE);
        fill_a_1_to_8();
        a_valid = 1'b1; a_ret[0] = mk(64'd9, 1'b0);
        tick();
        a_valid = 1'b0;
        check("a_ovf_flag",  a_ovf,   1);
        check("a_ovf_state", a_state, RVFI_ERROR);
        check("a_ovf_level", a_level, 8);
        check("a_ovf_oerr",  a_oerr,  0);
        a_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("a_drain_order", a_out.order, 64'(i));
            tick();
        end
        a_ready = 1'b0;
        check("a_drained_ovalid", a_ovalid, 0);
        check("a_drained_level",  a_level,  0);
        check_rec("a_drained_rec", a_out, '0);
        a_valid = 1'b1; a_ret[0] = mk(64'd9, 1'b0);
        tick();
        a_valid = 1'b0;
        check("a_err_blocks_level", a_level, 0);
        check("a_err_absorb_state", a_state, RVFI_ERROR);

        // Halt, then a stray strobe, then reset recovery.
        reset_a();
        for (int i = 1; i <= 4; i++) begin
            a_valid  = 1'b1;
            a_ret[0] = mk(64'(i), (i == 4));
            tick();
        end
        a_valid = 1'b0;
        check("a_halt_state", a_state, RVFI_HALTED);
        check("a_halt_level", a_level, 4);
        a_valid = 1'b1; a_ret[0] = mk(64'd5, 1'b0);
        tick();
        a_valid = 1'b0;
        check("a_halted_strobe_oerr",  a_oerr,  1);
        check("a_halted_strobe_state", a_state, RVFI_ERROR);
        check("a_halted_strobe_level", a_level, 4);
        reset_a();
        check("a_rec_state",  a_state,  RVFI_IDLE);
        check("a_rec_level",  a_level,  0);
        check("a_rec_ovf",    a_ovf,    0);
        check("a_rec_oerr",   a_oerr,   0);
        check("a_rec_ovalid", a_ovalid, 0);
        check_rec("a_rec_rec", a_out, '0);

        // Order restarts at ORDER_START; a skipped order is rejected.
        a_valid = 1'b1; a_ret[0] = mk(64'd1, 1'b0);
        tick();
        a_ret[0] = mk(64'd3, 1'b0);
        tick();
        a_valid = 1'b0;
        check("a_skip_oerr",  a_oerr,  1);
        check("a_skip_level", a_level, 1);
        check("a_skip_state", a_state, RVFI_ERROR);

        // Dual lane: good pair then bad pair.
        reset_b();
        push_b(2'b11, mk(64'd1, 1'b0), mk(64'd2, 1'b0));
        check("b_pair_level", b_level, 2);
        check("b_pair_state", b_state, RVFI_RUN);
        check("b_pair_head",  b_out.order, 1);
        push_b(2'b11, mk(64'd3, 1'b0), mk(64'd5, 1'b0));
        check("b_bad_oerr",  b_oerr,  1);
        check("b_bad_level", b_level, 2);
        check("b_bad_state", b_state, RVFI_ERROR);
        check("b_bad_ovf",   b_ovf,   0);

        // Lane 1 without lane 0.
        reset_b();
        push_b(2'b10, mk(64'd0, 1'b0), mk(64'd1, 1'b0));
        check("b_gap_oerr",  b_oerr,  1);
        check("b_gap_level", b_level, 0);

        // Halt on lane 0 with lane 1 valid.
        reset_b();
        check("b_rst_oerr", b_oerr, 0);
        push_b(2'b11, mk(64'd1, 1'b1), mk(64'd2, 1'b0));
        check("b_halt0_oerr",  b_oerr,  1);
        check("b_halt0_level", b_level, 0);
        check("b_halt0_state", b_state, RVFI_ERROR);

        // Halt on lane 1 is legal.
        reset_b();
        push_b(2'b11, mk(64'd1, 1'b0), mk(64'd2, 1'b1));
        check("b_halt1_state", b_state, RVFI_HALTED);
        check("b_halt1_level", b_level, 2);
        b_ready = 1'b1;
        check("b_halt1_head0", b_out.order, 1);
        tick();
        check_rec("b_halt1_head1", b_out, mk(64'd2, 1'b1));
        tick();
        b_ready = 1'b0;
        check("b_halt1_empty", b_ovalid, 0);

        // Free-space boundary with two lanes and a concurrent pop.
        reset_b();
        push_b(2'b11, mk(64'd1, 1'b0), mk(64'd2, 1'b0));
        push_b(2'b11, mk(64'd3, 1'b0), mk(64'd4, 1'b0));
        push_b(2'b11, mk(64'd5, 1'b0), mk(64'd6, 1'b0));
        push_b(2'b01, mk(64'd7, 1'b0), mk(64'd0, 1'b0));
        check("b_lvl7", b_level, 7);
        b_ready = 1'b1;
        push_b(2'b11, mk(64'd8, 1'b0), mk(64'd9, 1'b0));
        check("b_edge_level", b_level, 8);
        check("b_edge_ovf",   b_ovf,   0);
        check("b_edge_head",  b_out.order, 2);
        push_b(2'b11, mk(64'd10, 1'b0), mk(64'd11, 1'b0));
        b_ready = 1'b0;
        check("b_over_ovf",   b_ovf,   1);
        check("b_over_level", b_level, 7);
        check("b_over_state", b_state, RVFI_ERROR);
        check("b_over_head",  b_out.order, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ibex_rvfi_retire_fifo.md
IBEX_RVFI_RETIRE_FIFO -- requirements
Module: ibex_rvfi_retire_fifo

Interface
REQ-001 SHALL have parameter NRET, default 1, retire lanes per cycle (1 or 2).
REQ-002 SHALL have parameter DEPTH, default 8, buffer entries (power of two, >=4).
REQ-003 SHALL have parameter ORDER_START, default 64'd1, order expected on the first retirement after reset.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port ret_valid_i  input  NRET  per-lane retirement strobe.
REQ-007 SHALL have port ret_i  input  NRET x rvfi_rec_t  per-lane record {order[63:0], insn, pc_rdata, rd_addr[4:0], rd_wdata, trap, halt}.
REQ-008 SHALL have port out_valid_o  output  1  head entry available.
REQ-009 SHALL have port out_ready_i  input  1  consumer accepts head.
REQ-010 SHALL have port out_rec_o  output  rvfi_rec_t  head record.
REQ-011 SHALL have port level_o  output  $clog2(DEPTH+1)  occupied entries.
REQ-012 SHALL have port state_o  output  rvfi_fifo_state_e  current FSM state.
REQ-013 SHALL have port overflow_o  output  1  sticky overflow flag.
REQ-014 SHALL have port order_err_o  output  1  sticky order/protocol error flag.

Function
REQ-015 SHALL treat the lanes as compacted: lane 1 valid without lane 0 valid is a protocol error (order_err_o set, no push).
REQ-016 SHALL push all valid lanes of a cycle in lane order, lane 0 first, atomically.
REQ-017 SHALL compute free space as DEPTH - level + pop, where pop = out_valid_o & out_ready_i in the same cycle.
REQ-018 SHALL, when valid-lane count exceeds free space, push nothing that cycle, set overflow_o, enter ERROR.
REQ-019 SHALL hold expected order exp_q; lane k order SHALL equal exp_q + k; on match exp_q advances by the pushed count.
REQ-020 SHALL on any order mismatch push nothing that cycle, set order_err_o, enter ERROR.
REQ-021 SHALL present a pushed entry on out_valid_o/out_rec_o one cycle after the push edge (registered storage, no fall-through).
REQ-022 SHALL hold out_rec_o stable while out_valid_o=1 and out_ready_i=0.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; level_o never exceeds DEPTH.
REQ-024 SHALL implement FSM states IDLE, RUN, HALTED, ERROR.
REQ-025 SHALL transition IDLE->RUN on first successful push; RUN->HALTED when a pushed record has halt=1; any->ERROR per REQ-015/018/020/026.
REQ-026 SHALL treat any retirement strobe in HALTED as protocol error (order_err_o, ERROR).
REQ-027 SHALL keep ERROR absorbing until reset; pushes blocked, draining continues.
REQ-028 SHALL with NRET=2 and halt on lane 0 with lane 1 valid, flag protocol error and push nothing.

Reset
REQ-029 SHALL on rst_ni=0 at a clock edge set pointers and level_o to 0, out_valid_o=0, exp_q=ORDER_START, state IDLE, both sticky flags 0.
REQ-030 SHALL drive out_rec_o to all-zero while empty and after reset.
REQ-031 SHALL on reset mid-operation discard all buffered entries; no push or pop occurs in the reset cycle.

Structure
REQ-032 SHALL take rvfi_rec_t and rvfi_fifo_state_e from shared package ibex_rvfi_pkg.
REQ-033 SHALL contain one sub-module, ibex_rvfi_order_chk, computing per-lane order match and next exp_q.

Verification
REQ-034 NRET=1, DEPTH=8: orders 1..8 pushed, out_ready_i=0 -> level_o=8, out_rec_o.order=1, state RUN, no flags.
REQ-035 Full FIFO, push order 9 with out_ready_i=1 same cycle -> accepted, level_o stays 8, overflow_o=0.
REQ-036 Full FIFO, push order 9 with out_ready_i=0 -> no push, overflow_o=1, state ERROR, drain still yields orders 1..8.
REQ-037 NRET=2: lanes orders 1,2 then 3,5 -> first pair pushed, second rejected, order_err_o=1, level_o=2.
REQ-038 Push order 4 with halt=1 -> HALTED; next strobe -> order_err_o=1, ERROR; rst_ni low one edge -> IDLE, level_o=0, flags 0.
